// File: rtl/multicycle_control_unit_if.sv
// Instruction fetch handshake between the fetch stage (master) and the control unit (slave).
// A transfer completes on a rising clock edge where instr_valid and instr_ready are both high.
interface multicycle_control_unit_if;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;

    modport master (output instr_valid, output instruction, input instr_ready);
    modport slave  (input instr_valid, input instruction, output instr_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: latches one instruction per fetch handshake and sequences it over 1-3 steps.
// Optional macro CU_MEM_TIMEOUT_EN aborts a memory access stalled for TIMEOUT_CYCLES cycles and flags it as illegal.
module multicycle_control_unit #(
    parameter int unsigned CW_BITS        = 31,
    parameter int unsigned K_BITS         = 64,
    parameter int unsigned STATUS_BITS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    multicycle_control_unit_if.slave fetch,
    input  logic [STATUS_BITS-1:0]   status,
    input  logic                     mem_ready,
    output logic [CW_BITS-1:0]       controlWord,
    output logic [K_BITS-1:0]        K,
    output logic [1:0]               state,
    output logic                     done,
    output logic                     illegal
);

    if (CW_BITS < 11 || K_BITS < 32 || STATUS_BITS < 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("multicycle_control_unit: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EX0   = 2'd1,
        EX1   = 2'd2,
        MEM   = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_B, C_BCOND, C_BL, C_CB, C_BR,
        C_DT, C_IARITH, C_ILOGIC, C_IW, C_RALU
    } class_t;

    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_EOR   = 5'b01100;
    localparam logic [4:0] FS_PASSB = 5'b10000;

    localparam int unsigned REG_WRITE = 0;
    localparam int unsigned MEM_WRITE = 1;
    localparam int unsigned MEM_READ  = 2;
    localparam int unsigned PC_SEL    = 3;
    localparam int unsigned STAT_LOAD = 4;
    localparam int unsigned PC_INCR   = 5;

    state_t            cur_state, nxt_state;
    logic [31:0]       ir;
    logic [10:0]       opcode;
    class_t            iclass;
    logic [10:0]       cw;
    logic [4:0]        arith_fs, logic_fs, alu_fs;
    logic              flag_v, flag_c, flag_n, flag_z;
    logic              cond_true, cb_taken;
    logic [5:0]        iw_shift;
    logic [K_BITS-1:0] k_val;

`ifdef CU_MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;
    logic          mem_timeout;
`endif

    assign opcode = ir[31:21];
    assign flag_z = status[0];
    assign flag_n = status[1];
    assign flag_c = status[2];
    assign flag_v = status[3];

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_state <= FETCH;
            ir        <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == FETCH && fetch.instr_valid)
                ir <= fetch.instruction;
        end
    end

`ifdef CU_MEM_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset || cur_state != MEM)
            stall_cnt <= '0;
        else if (!mem_ready)
            stall_cnt <= stall_cnt + 1'b1;
    end

    // The counter reaches TIMEOUT_CYCLES at the edge ending this stall cycle, so abort now.
    assign mem_timeout = (cur_state == MEM) && !mem_ready &&
                         (stall_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        iclass = C_ILLEGAL;
        if (opcode[5]) begin
            case (opcode[10:8])
                3'b000:  iclass = C_B;
                3'b010:  iclass = C_BCOND;
                3'b100:  iclass = C_BL;
                3'b101:  iclass = C_CB;
                3'b110:  iclass = C_BR;
                default: iclass = C_ILLEGAL;
            endcase
        end else begin
            case (opcode[4:2])
                // An all-zero word (also the post-reset IR contents) is never a valid load/store.
                3'b000:  iclass = (opcode != '0) ? C_DT : C_ILLEGAL;
                3'b010:  iclass = C_IARITH;
                3'b100:  iclass = C_ILOGIC;
                3'b101:  iclass = C_IW;
                3'b110:  iclass = C_RALU;
                default: iclass = C_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        arith_fs = opcode[9] ? FS_SUB : FS_ADD;
        case (opcode[9:8])
            2'b01:   logic_fs = FS_ORR;
            2'b10:   logic_fs = FS_EOR;
            default: logic_fs = FS_AND;
        endcase
        case (iclass)
            C_IARITH: alu_fs = arith_fs;
            C_ILOGIC: alu_fs = logic_fs;
            default:  alu_fs = opcode[3] ? arith_fs : logic_fs;
        endcase
    end

    always_comb begin
        case (ir[3:0])
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = !flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = !flag_v;
            4'h8:    cond_true = flag_c && !flag_z;
            4'h9:    cond_true = !(flag_c && !flag_z);
            4'hA:    cond_true = (flag_n == flag_v);
            4'hB:    cond_true = (flag_n != flag_v);
            4'hC:    cond_true = !flag_z && (flag_n == flag_v);
            4'hD:    cond_true = !(!flag_z && (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
        cb_taken = flag_z ^ ir[24];
    end

    always_comb begin
        k_val    = '0;
        iw_shift = {ir[22:21], 4'b0000};
        case (iclass)
            C_IARITH, C_ILOGIC: k_val = {{(K_BITS-12){1'b0}}, ir[21:10]};
            C_DT:               k_val = {{(K_BITS-9){ir[20]}}, ir[20:12]};
            C_B, C_BL:          k_val = {{(K_BITS-28){ir[25]}}, ir[25:0], 2'b00};
            C_BCOND, C_CB:      k_val = {{(K_BITS-21){ir[23]}}, ir[23:5], 2'b00};
            C_IW: begin
                if ({26'd0, iw_shift} < K_BITS)
                    k_val = K_BITS'(ir[20:5]) << iw_shift;
            end
            default:            k_val = '0;
        endcase
        K = (cur_state == FETCH) ? '0 : k_val;
    end

    always_comb begin
        nxt_state = cur_state;
        cw        = '0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (cur_state)
            FETCH: begin
                if (fetch.instr_valid)
                    nxt_state = EX0;
            end
            EX0: begin
                nxt_state = FETCH;
                case (iclass)
                    C_RALU, C_IARITH, C_ILOGIC: begin
                        cw[REG_WRITE] = 1'b1;
                        cw[STAT_LOAD] = opcode[8];
                        cw[PC_INCR]   = 1'b1;
                        cw[10:6]      = alu_fs;
                        done          = 1'b1;
                    end
                    C_IW: begin
                        cw[REG_WRITE] = 1'b1;
                        cw[PC_INCR]   = 1'b1;
                        cw[10:6]      = FS_PASSB;
                        done          = 1'b1;
                    end
                    C_B, C_BR: begin
                        cw[PC_SEL] = 1'b1;
                        done       = 1'b1;
                    end
                    C_BCOND: begin
                        cw[PC_SEL]  = cond_true;
                        cw[PC_INCR] = !cond_true;
                        done        = 1'b1;
                    end
                    C_CB: begin
                        cw[PC_SEL]  = cb_taken;
                        cw[PC_INCR] = !cb_taken;
                        cw[10:6]    = FS_PASSB;
                        done        = 1'b1;
                    end
                    C_BL: begin
                        cw[REG_WRITE] = 1'b1;
                        nxt_state     = EX1;
                    end
                    C_DT: begin
                        cw[PC_INCR] = 1'b1;
                        cw[10:6]    = FS_ADD;
                        nxt_state   = MEM;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            EX1: begin
                cw[PC_SEL] = 1'b1;
                done       = 1'b1;
                nxt_state  = FETCH;
            end
            MEM: begin
                // The address add stays on the ALU for the whole access.
                cw[10:6]      = FS_ADD;
                cw[MEM_READ]  = ir[22];
                cw[MEM_WRITE] = !ir[22];
                if (mem_ready) begin
                    cw[REG_WRITE] = ir[22];
                    done          = 1'b1;
                    nxt_state     = FETCH;
                end
`ifdef CU_MEM_TIMEOUT_EN
                else if (mem_timeout) begin
                    cw        = '0;
                    illegal   = 1'b1;
                    nxt_state = FETCH;
                end
`endif
            end
            default: nxt_state = FETCH;
        endcase
    end

    assign fetch.instr_ready = (cur_state == FETCH);
    assign controlWord       = CW_BITS'(cw);
    assign state             = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; each task checks {instr_ready, state, done, illegal, controlWord, K}.
// Expected control words use FS codes ADD=01000, PASSB=10000 placed at bits [10:6].
module tb_multicycle_control_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  status;
    logic        mem_ready;
    logic [30:0] controlWord;
    logic [63:0] K;
    logic [1:0]  state;
    logic        done;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [99:0] obs, expv;
    logic [70:0] pobs, pexp;

    multicycle_control_unit_if fif();

    multicycle_control_unit #(
        .CW_BITS(31),
        .K_BITS(64),
        .STATUS_BITS(4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fetch(fif),
        .status(status),
        .mem_ready(mem_ready),
        .controlWord(controlWord),
        .K(K),
        .state(state),
        .done(done),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign obs  = {fif.instr_ready, state, done, illegal, controlWord, K};
    assign pobs = {fif.instr_ready, state, done, illegal, controlWord[2:0], K};

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        status = 4'b0000;
        mem_ready = 1'b0;
        fif.instr_valid = 1'b1;
        fif.instruction = 32'h8B020020;
        cyc(); cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, expv); end
        reset = 1'b1;
        fif.instr_valid = 1'b0;
        cyc(); #1;
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, expv); end
    endtask

    task automatic test_r_alu();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'h8B020020;
        #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL add_fetch: got %h expected %h", obs, expv); end
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h221, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL add_ex0: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL add_return: got %h expected %h", obs, expv); end
    endtask

    task automatic test_status_load();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hAB030041;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h231, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL adds_ex0: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL adds_return: got %h expected %h", obs, expv); end
    endtask

    task automatic test_load_stall();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hF85F8041;
        mem_ready = 1'b0;
        cyc(); fif.instr_valid = 1'b0; #1;
        pexp = {1'b0, 2'd1, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF8}; checks++;
        if (pobs !== pexp) begin errors++; $display("FAIL ldur_ex0: got %h expected %h", pobs, pexp); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            expv = {1'b0, 2'd3, 1'b0, 1'b0, 31'h204, 64'hFFFF_FFFF_FFFF_FFF8}; checks++;
            if (obs !== expv) begin errors++; $display("FAIL ldur_stall%0d: got %h expected %h", i, obs, expv); end
        end
        cyc(); mem_ready = 1'b1; #1;
        expv = {1'b0, 2'd3, 1'b1, 1'b0, 31'h205, 64'hFFFF_FFFF_FFFF_FFF8}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL ldur_mem_done: got %h expected %h", obs, expv); end
        cyc(); mem_ready = 1'b0; #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL ldur_return: got %h expected %h", obs, expv); end
    endtask

    task automatic test_store();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hF8010041;
        mem_ready = 1'b1;
        cyc(); fif.instr_valid = 1'b0; #1;
        pexp = {1'b0, 2'd1, 1'b0, 1'b0, 3'b000, 64'h10}; checks++;
        if (pobs !== pexp) begin errors++; $display("FAIL stur_ex0: got %h expected %h", pobs, pexp); end
        cyc(); #1;
        expv = {1'b0, 2'd3, 1'b1, 1'b0, 31'h202, 64'h10}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL stur_mem: got %h expected %h", obs, expv); end
        cyc(); mem_ready = 1'b0; #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL stur_return: got %h expected %h", obs, expv); end
    endtask

    task automatic test_movz();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hD2C24681;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h421, 64'h0000_1234_0000_0000}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL movz_ex0: got %h expected %h", obs, expv); end
        cyc(); #1;
    endtask

    task automatic test_bcond();
        status = 4'b0001;
        fif.instr_valid = 1'b1;
        fif.instruction = 32'h54FFFFA0;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h008, 64'hFFFF_FFFF_FFFF_FFF4}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL beq_taken: got %h expected %h", obs, expv); end
        cyc(); #1;
        status = 4'b0000;
        fif.instr_valid = 1'b1;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h020, 64'hFFFF_FFFF_FFFF_FFF4}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL beq_not_taken: got %h expected %h", obs, expv); end
        cyc(); #1;
    endtask

    task automatic test_cbnz();
        status = 4'b0000;
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hB5000081;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h408, 64'h10}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL cbnz_taken: got %h expected %h", obs, expv); end
        cyc(); #1;
    endtask

    task automatic test_bl_reset();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'h94000010;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b0, 1'b0, 31'h001, 64'h40}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL bl_ex0: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b0, 2'd2, 1'b1, 1'b0, 31'h008, 64'h40}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL bl_ex1: got %h expected %h", obs, expv); end
        reset = 1'b0;
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL bl_reset: got %h expected %h", obs, expv); end
        reset = 1'b1;
    endtask

    task automatic test_illegal();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'h00000000;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b0, 1'b1, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL illegal_zero: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL illegal_pulse_end: got %h expected %h", obs, expv); end
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hFFFFFFFF;
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b0, 1'b1, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL illegal_branch_group: got %h expected %h", obs, expv); end
        cyc(); #1;
    endtask

    task automatic test_back_to_back();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'h8B020020;
        cyc(); #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h221, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL b2b_first: got %h expected %h", obs, expv); end
        fif.instruction = 32'hD2C24681;
        #1;
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL b2b_ir_hold: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL b2b_fetch: got %h expected %h", obs, expv); end
        cyc(); fif.instr_valid = 1'b0; #1;
        expv = {1'b0, 2'd1, 1'b1, 1'b0, 31'h421, 64'h0000_1234_0000_0000}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL b2b_second: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL b2b_return: got %h expected %h", obs, expv); end
    endtask

`ifdef CU_MEM_TIMEOUT_EN
    task automatic test_timeout();
        fif.instr_valid = 1'b1;
        fif.instruction = 32'hF8010041;
        mem_ready = 1'b0;
        cyc(); fif.instr_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            expv = {1'b0, 2'd3, 1'b0, 1'b0, 31'h202, 64'h10}; checks++;
            if (obs !== expv) begin errors++; $display("FAIL timeout_stall%0d: got %h expected %h", i, obs, expv); end
        end
        cyc(); #1;
        expv = {1'b0, 2'd3, 1'b0, 1'b1, 31'h0, 64'h10}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL timeout_abort: got %h expected %h", obs, expv); end
        cyc(); #1;
        expv = {1'b1, 2'd0, 1'b0, 1'b0, 31'h0, 64'h0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL timeout_return: got %h expected %h", obs, expv); end
    endtask
`endif

    initial begin
        test_reset();
        test_r_alu();
        test_status_load();
        test_load_stall();
        test_store();
        test_movz();
        test_bcond();
        test_cbnz();
        test_bl_reset();
        test_illegal();
        test_back_to_back();
`ifdef CU_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle LEGv8 control decoder.
- Latches one instruction through a valid/ready fetch handshake and sequences it over 1-3 micro-steps.
- Stalls on memory, generalises immediate (K) generation to K_BITS, and flags illegal opcodes.
- Sits between the instruction fetch stage and the datapath (regfile, ALU, data memory, PC logic).

Parameters:
CW_BITS, 31, control word width (>= 11)
K_BITS, 64, constant/immediate output width (>= 32)
STATUS_BITS, 4, status flag width {V,C,N,Z}
TIMEOUT_CYCLES, 255, memory-stall limit (used only with CU_MEM_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
instr_valid  in  1  instruction word available
instruction  in  32  LEGv8 instruction word
instr_ready  out  1  high only in FETCH; handshake completes when instr_valid&&instr_ready at the clock edge
status  in  STATUS_BITS  {V,C,N,Z} from the flags register, sampled in EX0
mem_ready  in  1  data memory completes the access this cycle
controlWord  out  CW_BITS  datapath control
K  out  K_BITS  extended immediate
state  out  2  FETCH=0, EX0=1, EX1=2, MEM=3
done  out  1  one-cycle pulse on an instruction's final step
illegal  out  1  one-cycle pulse on an unrecognised opcode

Behaviour:
- Reset (reset==0 at edge): state=FETCH; instruction register=0; controlWord=0; K=0; done=0; illegal=0. Applies from any state; an in-flight access is abandoned with no done.
- controlWord fields: [0] RegWrite, [1] MemWrite, [2] MemRead, [3] PCsel (branch taken), [4] StatusLoad, [5] PCincr, [10:6] FS ALU function, [CW_BITS-1:11] = 0.
- Decode: opcode = IR[31:21]. opcode[5]=1 selects the branch group by opcode[10:8]: 000 B, 010 B.cond, 100 BL, 101 CBZ/CBNZ, 110 BR. Otherwise opcode[4:2] selects: 000 D_Transfer, 010 I_Arith, 100 I_Logic, 101 IW, 110 R_ALU. Every other code is illegal.
- FETCH: controlWord=0. On handshake, latch instruction into IR and go to EX0. IR changes only here.
- EX0, illegal opcode: illegal=1, controlWord=0, return to FETCH, no done.
- EX0, single-step classes (R_ALU, I_Arith, I_Logic, IW, B, B.cond, CBZ/CBNZ, BR): drive the class control word, done=1, go to FETCH. PCincr=1 unless PCsel=1.
- EX0, StatusLoad: asserted when opcode[8]=1 (S variants).
- EX0, conditional branches: B.cond evaluates IR[3:0] against status sampled in EX0. CBZ/CBNZ takes when (zero ^ IR[24]).
- D_Transfer: EX0 drives ALU add with K=sign-extended IR[20:12], then goes to MEM. MEM drives MemRead (IR[22]=1) or MemWrite (IR[22]=0) and holds every output while mem_ready=0. On the mem_ready=1 cycle it adds RegWrite for loads, sets done=1, and returns to FETCH. mem_ready high on the first MEM cycle gives 2-cycle latency.
- BL: EX0 drives RegWrite (X30 <- PC+4) and goes to EX1. EX1 drives PCsel=1, done=1, and goes to FETCH.
- K by class:
  - I_Arith/I_Logic: zero-extend IR[21:10].
  - D_Transfer: sign-extend IR[20:12].
  - B/BL: sign-extend IR[25:0], then shift left 2.
  - B.cond/CBZ: sign-extend IR[23:5], then shift left 2.
  - IW: zero-extend IR[20:5] shifted left by 16*IR[22:21]; a shift >= K_BITS gives 0.
  - R_ALU/BR: 0.
- K is valid in every non-FETCH state and 0 in FETCH.

Optional Feature:
- Macro CU_MEM_TIMEOUT_EN.
- When defined: a counter clears on entering MEM and increments on each MEM cycle with mem_ready=0. When it reaches TIMEOUT_CYCLES, illegal pulses once, controlWord drops to 0, state goes to FETCH, and done stays 0.
- When undefined: no counter exists, and MEM waits indefinitely.

Test Plan:
- ADD R_ALU (0x8B020020) with valid, mem_ready=x -> FETCH->EX0. The EX0 cycle has RegWrite=1, done=1, K=0. Back in FETCH after 2 cycles.
- LDUR with imm9=-8, mem_ready low 3 cycles -> EX0 K=0xFFFF_FFFF_FFFF_FFF8. MEM held 4 cycles with MemRead=1. RegWrite and done only on the 4th MEM cycle.
- MOVZ IW, imm16=0x1234, hw=2 -> K=0x0000_1234_0000_0000, done in EX0.
- B.EQ with Z=1, then Z=0 -> PCsel=1, then PCsel=0 (PCincr=1). K=sign-extended offset<<2.
- BL -> EX0 RegWrite=1, EX1 PCsel=1 with done. reset=0 driven during EX1 -> next cycle state=FETCH, all outputs 0, no done.
- Opcode 11'h000 -> illegal pulse in EX0, no done. With CU_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, STUR with mem_ready=0 -> illegal after 4 MEM cycles, then FETCH.
